// File: rtl/fp_add_scheduler_if.sv
// Bus bundle for fp_add_scheduler: two requester ports, the response port,
// the shared adder datapath connection and the busy flag.
interface fp_add_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        dp_sign1;
  logic        dp_sign2;
  logic [7:0]  dp_exp1;
  logic [7:0]  dp_exp2;
  logic [23:0] dp_mant1;
  logic [23:0] dp_mant2;
  logic [7:0]  dp_shift_amnt;
  logic        dp_shift_dir;
  logic [31:0] dp_result;
  logic        busy;

  // Scheduler side
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  resp_ready, dp_result,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data,
    output dp_sign1, dp_sign2, dp_exp1, dp_exp2, dp_mant1, dp_mant2,
    output dp_shift_amnt, dp_shift_dir, busy
  );

  // Requesters, consumer and datapath side
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output resp_ready, dp_result,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data,
    input  dp_sign1, dp_sign2, dp_exp1, dp_exp2, dp_mant1, dp_mant2,
    input  dp_shift_amnt, dp_shift_dir, busy
  );
endinterface

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP adder datapath between two
// requesters, with a zero-operand bypass and a held response port.
module fp_add_scheduler #(
  parameter int unsigned LAT = 1
) (
  input logic               clk,
  input logic               rst,
  fp_add_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        sign1_q, sign1_d, sign2_q, sign2_d;
  logic [7:0]  exp1_q, exp1_d, exp2_q, exp2_d;
  logic [23:0] mant1_q, mant1_d, mant2_q, mant2_d;
  logic [7:0]  amnt_q, amnt_d;
  logic        dir_q, dir_d;

  logic        grant;
  logic        rdy0, rdy1;
  logic        a_zero, b_zero;
  logic [7:0]  ea, eb;

  // Round-robin grant and ready generation; ready only offered in IDLE
  always_comb begin
    grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    rdy0  = (state_q == IDLE) && !rst && bus.req0_valid && !grant;
    rdy1  = (state_q == IDLE) && !rst && bus.req1_valid && grant;
  end

  // Next-state logic: accept, wait on the datapath or bypass, hold response
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    sign1_d      = sign1_q;
    sign2_d      = sign2_q;
    exp1_d       = exp1_q;
    exp2_d       = exp2_q;
    mant1_d      = mant1_q;
    mant2_d      = mant2_q;
    amnt_d       = amnt_q;
    dir_d        = dir_q;
    ea           = a_q[30:23];
    eb           = b_q[30:23];
    a_zero       = (a_q[30:0] == '0);
    b_zero       = (b_q[30:0] == '0);

    unique case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          id_d         = grant;
          last_grant_d = grant;
          a_d          = grant ? bus.req1_a : bus.req0_a;
          b_d          = grant ? bus.req1_b : bus.req0_b;
          cnt_d        = '0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // Zero bypass is resolved in the first EXEC cycle from the latched
        // operands; the datapath is loaded only when neither operand is zero,
        // then held for LAT cycles before dp_result is sampled.
        if (cnt_q == '0) begin
          if (a_zero || b_zero) begin
            if (a_zero && b_zero) resp_data_d = {a_q[31] & b_q[31], 31'b0};
            else if (a_zero)      resp_data_d = b_q;
            else                  resp_data_d = a_q;
            resp_valid_d = 1'b1;
            state_d      = DONE;
          end else begin
            sign1_d = a_q[31];
            sign2_d = b_q[31];
            exp1_d  = ea;
            exp2_d  = eb;
            mant1_d = {(ea != '0), a_q[22:0]};
            mant2_d = {(eb != '0), b_q[22:0]};
            amnt_d  = ea - eb;
            dir_d   = (eb > ea);
            cnt_d   = 4'd1;
          end
        end else if (cnt_q == LAT_CNT) begin
          resp_data_d  = bus.dp_result;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      exp1_q       <= '0;
      exp2_q       <= '0;
      mant1_q      <= '0;
      mant2_q      <= '0;
      amnt_q       <= '0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      sign1_q      <= sign1_d;
      sign2_q      <= sign2_d;
      exp1_q       <= exp1_d;
      exp2_q       <= exp2_d;
      mant1_q      <= mant1_d;
      mant2_q      <= mant2_d;
      amnt_q       <= amnt_d;
      dir_q        <= dir_d;
    end
  end

  assign bus.req0_ready    = rdy0;
  assign bus.req1_ready    = rdy1;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_id       = id_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.dp_sign1      = sign1_q;
  assign bus.dp_sign2      = sign2_q;
  assign bus.dp_exp1       = exp1_q;
  assign bus.dp_exp2       = exp2_q;
  assign bus.dp_mant1      = mant1_q;
  assign bus.dp_mant2      = mant2_q;
  assign bus.dp_shift_amnt = amnt_q;
  assign bus.dp_shift_dir  = dir_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: a LAT=1 instance carries the vector
// table and handshake sequences, a LAT=4 instance the mid-EXEC reset case.
module tb_fp_add_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_scheduler_if b1 ();
  fp_add_scheduler_if b4 ();

  fp_add_scheduler #(.LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fp_add_scheduler #(.LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  assign b4.req0_valid = b1.req0_valid;
  assign b4.req0_a     = b1.req0_a;
  assign b4.req0_b     = b1.req0_b;
  assign b4.req1_valid = b1.req1_valid;
  assign b4.req1_a     = b1.req1_a;
  assign b4.req1_b     = b1.req1_b;
  assign b4.resp_ready = b1.resp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Datapath model: the sum is presented only once the dp fields have been
  // stable for LAT cycles (and, when fld_chk is set, match the vector).
  logic [31:0] cur_sum = '0;
  logic        fld_chk = 1'b0;
  logic [23:0] e_m1 = '0, e_m2 = '0;
  logic [7:0]  e_amnt = '0;
  logic        e_dir = 1'b0;
  logic [65:0] snap1 = '0, snap4 = '0;
  int unsigned stab1 = 0, stab4 = 0;

  always @(negedge clk) begin
    if ({b1.dp_sign1, b1.dp_sign2, b1.dp_exp1, b1.dp_exp2, b1.dp_mant1, b1.dp_mant2} !== snap1) begin
      snap1 = {b1.dp_sign1, b1.dp_sign2, b1.dp_exp1, b1.dp_exp2, b1.dp_mant1, b1.dp_mant2};
      stab1 = 1;
    end else if (stab1 < 1000) stab1++;
    if (stab1 >= 1 && (!fld_chk || (b1.dp_mant1 == e_m1 && b1.dp_mant2 == e_m2 &&
        b1.dp_shift_amnt == e_amnt && b1.dp_shift_dir == e_dir)))
      b1.dp_result = cur_sum;
    else
      b1.dp_result = 32'hDEADBEEF;

    if ({b4.dp_sign1, b4.dp_sign2, b4.dp_exp1, b4.dp_exp2, b4.dp_mant1, b4.dp_mant2} !== snap4) begin
      snap4 = {b4.dp_sign1, b4.dp_sign2, b4.dp_exp1, b4.dp_exp2, b4.dp_mant1, b4.dp_mant2};
      stab4 = 1;
    end else if (stab4 < 1000) stab4++;
    b4.dp_result = (stab4 >= 4) ? cur_sum : 32'hDEADBEEF;
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        byp;
    logic [7:0]  amnt;
    logic        dir;
    logic [23:0] m1;
    logic [23:0] m2;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int i, input vec_t v);
    logic [23:0] pm1;
    logic [7:0]  pamnt;
    cur_sum = v.sum;
    e_m1 = v.m1; e_m2 = v.m2; e_amnt = v.amnt; e_dir = v.dir;
    fld_chk = 1'b1;
    pm1   = b1.dp_mant1;
    pamnt = b1.dp_shift_amnt;
    if (v.id) begin
      b1.req1_valid = 1'b1; b1.req1_a = v.a; b1.req1_b = v.b;
    end else begin
      b1.req0_valid = 1'b1; b1.req0_a = v.a; b1.req0_b = v.b;
    end
    #1;
    chk($sformatf("v%0d_ready", i), {b1.req1_ready, b1.req0_ready}, v.id ? 32'd2 : 32'd1);
    tick();  // transfer edge
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;
    chk($sformatf("v%0d_busy", i), b1.busy, 1);
    chk($sformatf("v%0d_early_valid", i), b1.resp_valid, 0);
    tick();
    if (v.byp) begin
      chk($sformatf("v%0d_valid", i), b1.resp_valid, 1);
      chk($sformatf("v%0d_data", i), b1.resp_data, v.data);
      chk($sformatf("v%0d_id", i), b1.resp_id, v.id);
      chk($sformatf("v%0d_dp_hold_mant1", i), b1.dp_mant1, pm1);
      chk($sformatf("v%0d_dp_hold_amnt", i), b1.dp_shift_amnt, pamnt);
    end else begin
      chk($sformatf("v%0d_mant1", i), b1.dp_mant1, v.m1);
      chk($sformatf("v%0d_mant2", i), b1.dp_mant2, v.m2);
      chk($sformatf("v%0d_amnt", i), b1.dp_shift_amnt, v.amnt);
      chk($sformatf("v%0d_dir", i), b1.dp_shift_dir, v.dir);
      chk($sformatf("v%0d_valid_lat", i), b1.resp_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), b1.resp_valid, 1);
      chk($sformatf("v%0d_data", i), b1.resp_data, v.data);
      chk($sformatf("v%0d_id", i), b1.resp_id, v.id);
    end
  endtask

  task automatic finish_resp(input int i);
    b1.resp_ready = 1'b1;
    tick();
    b1.resp_ready = 1'b0;
    chk($sformatf("v%0d_valid_drop", i), b1.resp_valid, 0);
    chk($sformatf("v%0d_idle", i), b1.busy, 0);
  endtask

  initial begin
    int seen;
    int found;
    int rc;

    vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 8'hFF, 1'b1, 24'h800000, 24'h800000, 32'h40400000};
    vecs[1] = '{1'b1, 32'h00000000, 32'hC0A00000, 32'h0,        1'b1, 8'h00, 1'b0, 24'h0,      24'h0,      32'hC0A00000};
    vecs[2] = '{1'b0, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 8'h00, 1'b0, 24'h0,      24'h0,      32'h80000000};
    vecs[3] = '{1'b1, 32'h40400000, 32'h40000000, 32'h40A00000, 1'b0, 8'h00, 1'b0, 24'hC00000, 24'h800000, 32'h40A00000};
    vecs[4] = '{1'b0, 32'h3F800000, 32'h80000000, 32'h0,        1'b1, 8'h00, 1'b0, 24'h0,      24'h0,      32'h3F800000};
    vecs[5] = '{1'b1, 32'h00000000, 32'h80000000, 32'h0,        1'b1, 8'h00, 1'b0, 24'h0,      24'h0,      32'h00000000};
    vecs[6] = '{1'b0, 32'h00400000, 32'h3F800000, 32'h3F800000, 1'b0, 8'h81, 1'b1, 24'h400000, 24'h800000, 32'h3F800000};
    vecs[7] = '{1'b1, 32'h42F00000, 32'h3F000000, 32'h42F10000, 1'b0, 8'h07, 1'b0, 24'hF00000, 24'h800000, 32'h42F10000};

    rst = 1'b1;
    b1.req0_valid = 1'b0; b1.req0_a = '0; b1.req0_b = '0;
    b1.req1_valid = 1'b0; b1.req1_a = '0; b1.req1_b = '0;
    b1.resp_ready = 1'b0;

    // Reset state, with a requester already valid
    #12;
    b1.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", b1.req0_ready, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_resp_valid", b1.resp_valid, 0);
    chk("rst_resp_data", b1.resp_data, 0);
    chk("rst_dp_mant1", b1.dp_mant1, 0);
    chk("rst_dp_amnt", b1.dp_shift_amnt, 0);
    b1.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset during the second EXEC cycle of the LAT=4 instance
    tick();
    cur_sum = 32'h40400000;
    b1.req0_valid = 1'b1; b1.req0_a = 32'h3F800000; b1.req0_b = 32'h40000000;
    #1;
    chk("r4_ready0", b4.req0_ready, 1);
    tick();
    b1.req0_valid = 1'b0;
    tick();
    chk("r4_busy_exec", b4.busy, 1);
    chk("r4_dp_loaded", b4.dp_mant1, 24'h800000);
    rst = 1'b1;
    #1;
    chk("r4_busy", b4.busy, 0);
    chk("r4_dp_mant1", b4.dp_mant1, 0);
    chk("r4_dp_amnt", b4.dp_shift_amnt, 0);
    chk("r4_dp_dir", b4.dp_shift_dir, 0);
    chk("r4_resp_valid", b4.resp_valid, 0);
    chk("r4_resp_data", b4.resp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (b4.resp_valid || b4.busy) seen++;
    end
    chk("r4_no_resp", seen, 0);
    b1.req0_valid = 1'b1;
    b1.req1_valid = 1'b1; b1.req1_a = 32'h40400000; b1.req1_b = 32'h40000000;
    #1;
    chk("r4_first_grant", {b4.req1_ready, b4.req0_ready}, 32'd1);
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;

    // Vector table on the LAT=1 instance
    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      finish_resp(i);
    end

    // Backpressure: five edges with resp_ready low while req1 waits
    run_vec(8, vecs[0]);
    b1.req1_valid = 1'b1; b1.req1_a = 32'h40400000; b1.req1_b = 32'h40000000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("bp%0d_valid", k), b1.resp_valid, 1);
      chk($sformatf("bp%0d_data", k), b1.resp_data, 32'h40400000);
      chk($sformatf("bp%0d_id", k), b1.resp_id, 0);
      chk($sformatf("bp%0d_readys", k), {b1.req1_ready, b1.req0_ready}, 0);
    end
    b1.resp_ready = 1'b1;
    tick();
    chk("bp_done_valid", b1.resp_valid, 0);
    chk("bp_done_idle", b1.busy, 0);
    chk("bp_done_ready1", b1.req1_ready, 1);
    b1.req1_valid = 1'b0;
    b1.resp_ready = 1'b0;

    // Contention after a fresh reset: grants alternate starting with req0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fld_chk = 1'b0;
    cur_sum = 32'h12345678;
    b1.req0_valid = 1'b1; b1.req0_a = 32'h3F800000; b1.req0_b = 32'h40000000;
    b1.req1_valid = 1'b1; b1.req1_a = 32'h40400000; b1.req1_b = 32'h40000000;
    b1.resp_ready = 1'b1;
    #1;
    found = 0;
    rc = 0;
    for (int cyc = 0; cyc < 60 && found < 4; cyc++) begin
      if (b1.req0_ready || b1.req1_ready) begin
        chk($sformatf("cont_grant%0d", found), {b1.req1_ready, b1.req0_ready}, (found % 2) ? 32'd2 : 32'd1);
        found++;
      end
      if (b1.resp_valid) begin
        chk($sformatf("cont_resp_id%0d", rc), b1.resp_id, rc % 2);
        rc++;
      end
      tick();
    end
    chk("cont_grant_count", found, 4);
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;
    b1.resp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
